// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t     : FSM state encodings (IDLE=0, WAIT=1, RESP=2)
//   LAT_MIN/MAX : legal range of the response latency
//   lat_clamp   : forces a latency parameter into the legal range
//   misaligned  : word-alignment test on the low two address bits
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned LAT_MIN = 32'd1;
    localparam int unsigned LAT_MAX = 32'd15;

    // Out-of-range latencies are pulled to the nearest legal value so the
    // 4-bit counter can never be loaded with a wrapped value.
    function automatic int unsigned lat_clamp(input int unsigned lat);
        if (lat < LAT_MIN) begin
            return LAT_MIN;
        end else if (lat > LAT_MAX) begin
            return LAT_MAX;
        end else begin
            return lat;
        end
    endfunction

    function automatic logic misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'd0);
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH x 8 byte storage with a 4-byte big-endian access port.
//   clk   : clock
//   clr   : synchronous clear of every byte
//   we    : commit wdata at addr..addr+3 on this edge
//   addr  : byte address of the most significant byte
//   wdata : store word, [31:24] lands at addr
//   rdata : combinational load word, m[addr] in [31:24]
// Byte indices wrap modulo DEPTH because the sum is kept at ADDR_W bits.
module dmem_byte_array #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [DEPTH];

    // Storage update: clear has priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 8'd0;
            end
        end else if (we) begin
            for (int k = 0; k < 4; k++) begin
                mem[addr + ADDR_W'(k)] <= wdata[31 - 8*k -: 8];
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= mem[i];
            end
        end
    end

    // Big-endian gather of the four bytes starting at addr.
    always_comb begin
        rdata = 32'd0;
        for (int k = 0; k < 4; k++) begin
            rdata[31 - 8*k -: 8] = mem[addr + ADDR_W'(k)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one word load/store request,
// waits a fixed latency, then presents a response until it is taken.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only when idle)
//   req_write/req_addr/req_wdata : request payload
//   resp_valid/resp_ready        : response handshake
//   resp_rdata/resp_err          : load data (0 for stores/errors), misalignment flag
//   busy                         : a transaction is in flight
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [3:0] LAT_LOAD = 4'(lat_clamp(LATENCY) - 32'd1);

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic                write_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic                req_ready_r, resp_valid_r, resp_err_r, busy_r;
    logic [31:0]         resp_rdata_r;

    logic                accept_s, access_s, err_s, we_s;
    logic                acc_write_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [31:0]         acc_wdata_s;
    logic [31:0]         mem_rdata_s;
    logic                unused_addr_s;

    assign unused_addr_s = ^req_addr[31:ADDR_W];

    assign accept_s = req_valid && req_ready_r;

    // The access happens on the edge that enters RESP. With a latency of one
    // that edge is the acceptance edge, so the live request is used instead
    // of the latched copy.
    assign access_s    = (state_r == ST_IDLE) ? (accept_s && (LAT_LOAD == 4'd0))
                                              : ((state_r == ST_WAIT) && (cnt_r == 4'd0));
    assign acc_write_s = (state_r == ST_IDLE) ? req_write : write_r;
    assign acc_addr_s  = (state_r == ST_IDLE) ? req_addr[ADDR_W-1:0] : addr_r;
    assign acc_wdata_s = (state_r == ST_IDLE) ? req_wdata : wdata_r;
    assign err_s       = (ALIGN_CHECK != 32'd0) && misaligned(acc_addr_s[1:0]);
    assign we_s        = access_s && acc_write_s && !err_s;

    dmem_byte_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .clr   (rst),
        .we    (we_s),
        .addr  (acc_addr_s),
        .wdata (acc_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Next-state and latency-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_s   = LAT_LOAD;
                    state_s = (LAT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, request latch and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            write_r      <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= 32'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            req_ready_r  <= (state_s == ST_IDLE);
            busy_r       <= (state_s != ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            if (accept_s) begin
                write_r <= req_write;
                addr_r  <= req_addr[ADDR_W-1:0];
                wdata_r <= req_wdata;
            end else begin
                write_r <= write_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
            if (access_s) begin
                resp_rdata_r <= (!acc_write_s && !err_s) ? mem_rdata_s : 32'd0;
                resp_err_r   <= err_s;
            end else if ((state_r == ST_RESP) && resp_ready) begin
                resp_rdata_r <= 32'd0;
                resp_err_r   <= 1'b0;
            end else begin
                resp_rdata_r <= resp_rdata_r;
                resp_err_r   <= resp_err_r;
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (alignment checking on and off)
// receive identical requests; a reference byte-array model per instance
// pushes expected responses into a queue that is popped when resp_valid rises.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_busy;
    logic [31:0] a_resp_rdata;
    logic        n_req_ready, n_resp_valid, n_resp_err, n_busy;
    logic [31:0] n_resp_rdata;

    typedef struct {
        logic [31:0] a_rdata;
        logic        a_err;
        logic [31:0] n_rdata;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ma [32];
    logic [7:0] mn [32];
    int         nerr = 0;
    int         nchk = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(LAT), .ALIGN_CHECK(1)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
    );

    dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(LAT), .ALIGN_CHECK(0)) u_n (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(n_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(n_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(n_resp_rdata), .resp_err(n_resp_err), .busy(n_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            ma[i] = 8'd0;
            mn[i] = 8'd0;
        end
    endtask

    task automatic model_push(input logic w, input logic [31:0] addr, input logic [31:0] wd);
        exp_t       e;
        logic [4:0] a5;
        logic [4:0] ix;
        a5 = addr[4:0];
        e.a_rdata = 32'd0;
        e.a_err   = 1'b0;
        e.n_rdata = 32'd0;
        for (int k = 0; k < 4; k++) begin
            ix = a5 + 5'(k);
            if (w) mn[ix] = wd[31 - 8*k -: 8];
            else   e.n_rdata[31 - 8*k -: 8] = mn[ix];
        end
        if (a5[1:0] != 2'd0) begin
            e.a_err = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                ix = a5 + 5'(k);
                if (w) ma[ix] = wd[31 - 8*k -: 8];
                else   e.a_rdata[31 - 8*k -: 8] = ma[ix];
            end
        end
        sb.push_back(e);
    endtask

    // One transaction; 'stall' cycles of resp_ready low with a competing request.
    task automatic txn(input logic w, input logic [31:0] addr, input logic [31:0] wd, input int stall);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("req_ready_before", {a_req_ready, n_req_ready}, 32'd3);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(posedge clk);
        model_push(w, addr, wd);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", {a_busy, a_req_ready}, 32'd2);
        lat = 0;
        while (!a_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT);
        check("resp_valid_n", n_resp_valid, 32'd1);
        e = sb.pop_front();
        check("rdata_a", a_resp_rdata, e.a_rdata);
        check("err_a", a_resp_err, e.a_err);
        check("rdata_n", n_resp_rdata, e.n_rdata);
        check("err_n", n_resp_err, 32'd0);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = addr + 32'd4;
            @(negedge clk);
            check("stall_valid", a_resp_valid, 32'd1);
            check("stall_rdata", a_resp_rdata, e.a_rdata);
            check("stall_req_ready", a_req_ready, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("after_hs_valid", {a_resp_valid, n_resp_valid}, 32'd0);
        check("after_hs_rdata", a_resp_rdata | n_resp_rdata, 32'd0);
        check("after_hs_err", a_resp_err, 32'd0);
        check("after_hs_idle", {a_busy, a_req_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        model_clear();

        // Reset then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", {a_req_ready, n_req_ready}, 32'd3);
        check("rst_resp_valid", {a_resp_valid, n_resp_valid}, 32'd0);
        check("rst_rdata", a_resp_rdata | n_resp_rdata, 32'd0);
        check("rst_err_busy", {a_resp_err, n_resp_err, a_busy, n_busy}, 32'd0);
        txn(1'b0, 32'd0, 32'd0, 0);

        // Store then load with back-pressure.
        txn(1'b1, 32'd8, 32'hDEADBEEF, 0);
        txn(1'b0, 32'd8, 32'd0, 5);
        check("byte8", u_a.u_mem.mem[8], 32'h000000DE);
        check("byte11", u_a.u_mem.mem[11], 32'h000000EF);

        // Wrap-around store at 30 (error on the checking instance).
        txn(1'b1, 32'd30, 32'h11223344, 0);
        check("wrap_b30", u_n.u_mem.mem[30], 32'h00000011);
        check("wrap_b31", u_n.u_mem.mem[31], 32'h00000022);
        check("wrap_b0", u_n.u_mem.mem[0], 32'h00000033);
        check("wrap_b1", u_n.u_mem.mem[1], 32'h00000044);
        check("wrap_a_b0", u_a.u_mem.mem[0], 32'h00000000);
        txn(1'b0, 32'd30, 32'd0, 0);

        // Misaligned store suppressed on the checking instance.
        txn(1'b1, 32'd5, 32'hFFFFFFFF, 0);
        txn(1'b0, 32'd4, 32'd0, 0);

        // Upper address bits ignored, mixed traffic.
        for (int i = 0; i < 8; i++) begin
            txn(1'($urandom_range(0, 1)), 32'hABC00000 | 32'($urandom_range(0, 31)),
                32'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of WAIT aborts the store.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd12;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("midrst_state", {a_resp_valid, a_busy, a_req_ready}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_resp", {a_resp_valid, n_resp_valid, a_busy}, 32'd0);
        end
        txn(1'b0, 32'd12, 32'd0, 0);
        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
